mig_addr_buf: RTL and testbench

MIG_ADDR_BUF -- requirements
Module: mig_addr_buf

---
 rtl/page_hotness_pkg.sv | 17 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/mig_addr_buf.sv | 162 ++++++++++++++++
 tb/tb_mig_addr_buf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/page_hotness_pkg.sv
// Purpose: shared definitions for the migration address buffer: default widths,
//          rd_data field positions and the MMIO read FSM state enum.
package page_hotness_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 28;
  localparam int unsigned CNT_SIZE_DEF  = 16;

  // rd_data layout: bit 31 flags a real entry, address sits in the low bits.
  localparam int unsigned RD_DATA_W     = 32;
  localparam int unsigned RD_VALID_BIT  = 31;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO storage and pointer logic for mig_addr_buf.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push_i, data_i    write request (ignored when full) and write data
//   pop_i             read request (ignored when empty)
//   flush_i           zero both pointers; overrides same-cycle push/pop
//   head_o            entry at the read pointer
//   full_o, empty_o   status from registered pointers only
//   count_o           current entry count
module sync_fifo #(
  parameter int unsigned WIDTH      = 28,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   count_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_BITS:0] wptr_q, wptr_d;
  logic [DEPTH_BITS:0] rptr_q, rptr_d;
  logic                push_ok;
  logic                pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wptr_q[DEPTH_BITS] != rptr_q[DEPTH_BITS]) &&
                   (wptr_q[DEPTH_BITS-1:0] == rptr_q[DEPTH_BITS-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[DEPTH_BITS-1:0]];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Pointer next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + (DEPTH_BITS+1)'(1);
      if (pop_ok)  rptr_d = rptr_q + (DEPTH_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[DEPTH_BITS-1:0]] <= data_i;
  end

endmodule

// File: rtl/mig_addr_buf.sv
// Purpose: buffers hot cache-line addresses from the tracker and hands them to
//          an MMIO reader one at a time, counting drops and (optionally) duplicates.
// Configuration: define MIG_ADDR_DEDUP_EN to suppress an address equal to the
//          last written one; otherwise dup_cnt is tied to zero.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   mig_addr_en, mig_addr       upstream address valid and address
//   mig_addr_ready              buffer not full
//   flush                       discard all buffered entries
//   rd_req                      MMIO pop request
//   rd_valid, rd_data           one-cycle response: {valid, pad, address}
//   occupancy                   entry count
//   drop_cnt, dup_cnt           saturating loss / duplicate counters
module mig_addr_buf
  import page_hotness_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DEPTH_BITS = 4,
  parameter int unsigned CNT_SIZE   = CNT_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mig_addr_en,
  input  logic [ADDR_SIZE-1:0]  mig_addr,
  output logic                  mig_addr_ready,
  input  logic                  flush,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [RD_DATA_W-1:0]  rd_data,
  output logic [DEPTH_BITS:0]   occupancy,
  output logic [CNT_SIZE-1:0]   drop_cnt,
  output logic [CNT_SIZE-1:0]   dup_cnt
);

  rd_state_e              state_q, state_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [RD_DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_SIZE-1:0]    drop_q, drop_d;
  logic [ADDR_SIZE-1:0]   head;
  logic [RD_DATA_W-1:0]   head_word_c;
  logic                   full, empty;
  logic                   push_c, pop_c;
  logic                   handshake_c;

  assign mig_addr_ready = !full;
  assign handshake_c    = mig_addr_en && mig_addr_ready && !flush;

  sync_fifo #(
    .WIDTH      (ADDR_SIZE),
    .DEPTH      (DEPTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (mig_addr),
    .pop_i   (pop_c),
    .flush_i (flush),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

`ifdef MIG_ADDR_DEDUP_EN
  logic [ADDR_SIZE-1:0] last_q, last_d;
  logic                 last_vld_q, last_vld_d;
  logic [CNT_SIZE-1:0]  dup_q, dup_d;
  logic                 is_dup_c;

  assign is_dup_c = last_vld_q && (mig_addr == last_q);
  assign push_c   = handshake_c && !is_dup_c;

  // Last-written tracking and duplicate counter.
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    dup_d      = dup_q;
    if (flush) begin
      last_vld_d = 1'b0;
    end else if (push_c) begin
      last_d     = mig_addr;
      last_vld_d = 1'b1;
    end
    if (handshake_c && is_dup_c && (dup_q != '1)) dup_d = dup_q + CNT_SIZE'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      dup_q      <= '0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      dup_q      <= dup_d;
    end
  end

  assign dup_cnt = dup_q;
`else
  assign push_c  = handshake_c;
  assign dup_cnt = '0;
`endif

  // Response word for a non-empty pop.
  always_comb begin
    head_word_c                  = '0;
    head_word_c[ADDR_SIZE-1:0]   = head;
    head_word_c[RD_VALID_BIT]    = 1'b1;
  end

  // Read FSM next-state and response; empty reads still return a valid pulse.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    pop_c      = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_req) begin
          state_d    = RD_RESP;
          rd_valid_d = 1'b1;
          if (!empty) begin
            rd_data_d = head_word_c;
            pop_c     = 1'b1;
          end else begin
            rd_data_d = '0;
          end
        end
      end
      RD_RESP: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Drop counter: any offered address while full is lost.
  always_comb begin
    drop_d = drop_q;
    if (mig_addr_en && !mig_addr_ready && (drop_q != '1)) drop_d = drop_q + CNT_SIZE'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      drop_q     <= drop_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mig_addr_buf.sv
// Purpose: directed self-checking bench for mig_addr_buf (default parameters).
module tb_mig_addr_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        mig_addr_en;
  logic [27:0] mig_addr;
  logic        mig_addr_ready;
  logic        flush;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [4:0]  occupancy;
  logic [15:0] drop_cnt;
  logic [15:0] dup_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mig_addr_buf dut (
    .clk            (clk),
    .rst            (rst),
    .mig_addr_en    (mig_addr_en),
    .mig_addr       (mig_addr),
    .mig_addr_ready (mig_addr_ready),
    .flush          (flush),
    .rd_req         (rd_req),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .occupancy      (occupancy),
    .drop_cnt       (drop_cnt),
    .dup_cnt        (dup_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [27:0] a);
    mig_addr_en = 1'b1;
    mig_addr    = a;
    tick();
    mig_addr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, rd_data, exp);
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mig_addr_en = 1'b0; mig_addr = '0; flush = 1'b0; rd_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_occ",   {27'd0, occupancy}, 32'd0);
    check("rst_ready", {31'd0, mig_addr_ready}, 32'd1);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data",  rd_data, 32'd0);
    check("rst_drop",  {16'd0, drop_cnt}, 32'd0);
    check("rst_dup",   {16'd0, dup_cnt}, 32'd0);

    // Single push then pop.
    push(28'h0000123);
    check("single_occ1", {27'd0, occupancy}, 32'd1);
    pop_check("single_pop", 32'h8000_0123);
    check("single_occ0", {27'd0, occupancy}, 32'd0);
    check("single_vld_pulse", {31'd0, rd_valid}, 32'd0);

    // Read on empty.
    pop_check("empty_pop", 32'h0000_0000);

    // Overfill: 18 pushes, 2 drops, in-order drain.
    mig_addr_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      mig_addr = 28'h100 + 28'(i);
      tick();
      if (i == 15) check("fill_ready0", {31'd0, mig_addr_ready}, 32'd0);
    end
    mig_addr_en = 1'b0;
    check("fill_drop", {16'd0, drop_cnt}, 32'd2);
    check("fill_occ",  {27'd0, occupancy}, 32'd16);
    for (int i = 0; i < 16; i++) pop_check("drain", 32'h8000_0100 + 32'(i));
    check("drain_occ", {27'd0, occupancy}, 32'd0);

    // Full FIFO: simultaneous push and pop -> pop wins, push dropped.
    for (int i = 0; i < 16; i++) push(28'h200 + 28'(i));
    mig_addr_en = 1'b1; mig_addr = 28'h999; rd_req = 1'b1;
    tick();
    mig_addr_en = 1'b0; rd_req = 1'b0;
    check("fullpp_data", rd_data, 32'h8000_0200);
    check("fullpp_occ",  {27'd0, occupancy}, 32'd15);
    check("fullpp_drop", {16'd0, drop_cnt}, 32'd3);
    tick();
    for (int i = 1; i < 16; i++) pop_check("fullpp_drain", 32'h8000_0200 + 32'(i));
    check("fullpp_empty", {27'd0, occupancy}, 32'd0);

    // Flush with same-cycle read.
    for (int i = 0; i < 5; i++) push(28'h300 + 28'(i));
    check("flush_pre_occ", {27'd0, occupancy}, 32'd5);
    flush = 1'b1; rd_req = 1'b1;
    tick();
    flush = 1'b0; rd_req = 1'b0;
    check("flush_occ", {27'd0, occupancy}, 32'd0);
    tick();
    pop_check("flush_after", 32'h0000_0000);
    check("flush_keeps_drop", {16'd0, drop_cnt}, 32'd3);

    // Push and pop together on non-empty: occupancy unchanged.
    push(28'h055);
    mig_addr_en = 1'b1; mig_addr = 28'h066; rd_req = 1'b1;
    tick();
    mig_addr_en = 1'b0; rd_req = 1'b0;
    check("pp_data", rd_data, 32'h8000_0055);
    check("pp_occ",  {27'd0, occupancy}, 32'd1);
    tick();
    pop_check("pp_second", 32'h8000_0066);

    // Pop on empty with same-cycle push: no bypass.
    mig_addr_en = 1'b1; mig_addr = 28'h077; rd_req = 1'b1;
    tick();
    mig_addr_en = 1'b0; rd_req = 1'b0;
    check("nobypass_data", rd_data, 32'h0000_0000);
    check("nobypass_occ",  {27'd0, occupancy}, 32'd1);
    tick();
    pop_check("nobypass_later", 32'h8000_0077);

    // Duplicate suppression (back-to-back pushes).
    do_flush();
    mig_addr_en = 1'b1;
    mig_addr = 28'hA; tick();
    mig_addr = 28'hA; tick();
    mig_addr = 28'hB; tick();
    mig_addr = 28'hA; tick();
    mig_addr_en = 1'b0;
`ifdef MIG_ADDR_DEDUP_EN
    check("dedup_occ", {27'd0, occupancy}, 32'd3);
    check("dedup_cnt", {16'd0, dup_cnt}, 32'd1);
`else
    check("dedup_occ", {27'd0, occupancy}, 32'd4);
    check("dedup_cnt", {16'd0, dup_cnt}, 32'd0);
`endif

    // Asynchronous reset mid-operation with a pending response.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_occ",   {27'd0, occupancy}, 32'd0);
    check("async_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("async_rst_data",  rd_data, 32'd0);
    check("async_rst_drop",  {16'd0, drop_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, mig_addr_ready}, 32'd1);
    pop_check("post_rst_empty", 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
